// File: rtl/cc_pkg.sv
// Shared definitions for the cruise-control input conditioner: timing defaults,
// input slot indices and the adjust FSM state encoding.
package cc_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 16;
  localparam int DEF_REPEAT_RATE     = 4;
  localparam int DEF_CNT_W           = 8;

  // Bit positions of the raw inputs inside the top-level input vector.
  localparam int IN_SET    = 0;
  localparam int IN_ACCEL  = 1;
  localparam int IN_COAST  = 2;
  localparam int IN_CANCEL = 3;
  localparam int IN_RESUME = 4;
  localparam int IN_BRAKE  = 5;
  localparam int IN_THR    = 6;
  localparam int N_IN      = 7;

  // Adjust FSM shared by accel and coast.
  typedef logic [1:0] adj_state_t;
  localparam adj_state_t ADJ_IDLE   = 2'd0;
  localparam adj_state_t ADJ_DELAY  = 2'd1;
  localparam adj_state_t ADJ_REPEAT = 2'd2;
  localparam adj_state_t ADJ_LOCK   = 2'd3;

endpackage

// File: rtl/cc_debounce.sv
// Single-input debouncer: a level change is accepted after DEBOUNCE_CYCLES
// consecutive differing samples; FAST_RISE accepts a rise on its first sample.
module cc_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter bit FAST_RISE       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic stable_next
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // stable_next is exported so the top can register pulses in the same edge
  // that the stable level changes.
  always_comb begin
    cnt_next    = cnt;
    stable_next = stable;
    if (raw == stable) begin
      cnt_next = '0;
    end else if (FAST_RISE && raw) begin
      stable_next = 1'b1;
      cnt_next    = '0;
    end else if (cnt >= LAST) begin
      stable_next = raw;
      cnt_next    = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      stable <= stable_next;
    end
  end

endmodule

// File: rtl/cc_input_conditioner.sv
// Conditions raw cruise-control switches and pedals into debounced levels and
// single-cycle command pulses, with accel/coast auto-repeat and brake/cancel priority.
module cc_input_conditioner
  import cc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_accel,
  input  logic btn_coast,
  input  logic btn_cancel,
  input  logic btn_resume,
  input  logic pedal_brake,
  input  logic pedal_thr,
  output logic set,
  output logic accel,
  output logic coast,
  output logic cancel,
  output logic resume,
  output logic brake,
  output logic throttle,
  output logic conflict
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] stb;
  logic [N_IN-1:0] stb_next;
  logic [4:0]      rise;

  assign raw_in = {pedal_thr, pedal_brake, btn_resume, btn_cancel,
                   btn_coast, btn_accel, btn_set};

  for (genvar i = 0; i < N_IN; i++) begin : g_db
    cc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .FAST_RISE      (i == IN_BRAKE)
    ) u_db (
      .clk        (clk),
      .reset      (reset),
      .raw        (raw_in[i]),
      .stable     (stb[i]),
      .stable_next(stb_next[i])
    );
  end

  assign rise     = stb_next[4:0] & ~stb[4:0];
  assign brake    = stb[IN_BRAKE];
  assign throttle = stb[IN_THR];

  // Throttle only needs its registered level.
  logic unused_thr_next;
  assign unused_thr_next = stb_next[IN_THR];

  logic brk_now;
  logic acc_now;
  logic cst_now;
  assign brk_now = stb_next[IN_BRAKE];
  assign acc_now = stb_next[IN_ACCEL];
  assign cst_now = stb_next[IN_COAST];

  // Adjust FSM; dir selects the active button (0 accel, 1 coast).
  adj_state_t       state;
  adj_state_t       state_next;
  logic             dir;
  logic             dir_next;
  logic [CNT_W-1:0] rcnt;
  logic [CNT_W-1:0] rcnt_next;
  logic             adj_pulse;
  logic             held;
  logic [CNT_W-1:0] rlast;

  assign held  = dir ? cst_now : acc_now;
  assign rlast = (state == ADJ_DELAY) ? DELAY_LAST : RATE_LAST;

  always_comb begin
    state_next = state;
    dir_next   = dir;
    rcnt_next  = rcnt;
    adj_pulse  = 1'b0;
    if (brk_now) begin
      state_next = ADJ_IDLE;
      rcnt_next  = '0;
    end else if (acc_now && cst_now) begin
      state_next = ADJ_LOCK;
      rcnt_next  = '0;
    end else begin
      case (state)
        ADJ_IDLE: begin
          if (rise[IN_ACCEL] || rise[IN_COAST]) begin
            state_next = ADJ_DELAY;
            dir_next   = rise[IN_COAST];
            rcnt_next  = '0;
            adj_pulse  = 1'b1;
          end
        end
        ADJ_DELAY, ADJ_REPEAT: begin
          if (!held) begin
            state_next = ADJ_IDLE;
            rcnt_next  = '0;
          end else if (rcnt >= rlast) begin
            state_next = ADJ_REPEAT;
            rcnt_next  = '0;
            adj_pulse  = 1'b1;
          end else begin
            rcnt_next = rcnt + 1'b1;
          end
        end
        default: begin
          if (!acc_now && !cst_now) state_next = ADJ_IDLE;
        end
      endcase
    end
  end

  // Pulse priority: cancel > set > resume > accel/coast; brake masks all but cancel.
  logic cancel_d;
  logic set_d;
  logic resume_d;
  logic adj_ok;

  always_comb begin
    cancel_d = rise[IN_CANCEL];
    set_d    = rise[IN_SET] & ~brk_now & ~cancel_d;
    resume_d = rise[IN_RESUME] & ~brk_now & ~cancel_d & ~rise[IN_SET];
    adj_ok   = adj_pulse & ~(cancel_d | set_d | resume_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ADJ_IDLE;
      dir      <= 1'b0;
      rcnt     <= '0;
      set      <= 1'b0;
      accel    <= 1'b0;
      coast    <= 1'b0;
      cancel   <= 1'b0;
      resume   <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_next;
      dir      <= dir_next;
      rcnt     <= rcnt_next;
      set      <= set_d;
      accel    <= adj_ok & ~dir_next;
      coast    <= adj_ok & dir_next;
      cancel   <= cancel_d;
      resume   <= resume_d;
      conflict <= acc_now & cst_now;
    end
  end

endmodule
